// File: rtl/udma_cpi_frame_sched.sv
// Ping-pong CPI frame scheduler: arms the RX channel on alternating buffers and gates capture on vsync.
// One-cycle registered response to every event; a frame with no free buffer is dropped and flagged.
module udma_cpi_frame_sched #(
  parameter int L2_AWIDTH_NOAL = 19,
  parameter int TRANS_SIZE     = 20
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_buf0_addr_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_buf1_addr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_frame_size_i,
  input  logic [7:0]                cfg_nframes_i,
  input  logic                      buf_release_i,
  input  logic                      buf_release_idx_i,
  input  logic                      vsync_i,
  input  logic                      ch_rx_en_i,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o,
  output logic [TRANS_SIZE-1:0]     cfg_rx_size_o,
  output logic                      cfg_rx_en_o,
  output logic                      cfg_rx_clr_o,
  output logic                      cam_en_o,
  output logic                      frame_done_o,
  output logic                      frame_idx_o,
  output logic                      short_frame_o,
  output logic                      overrun_o,
  output logic                      busy_o,
  output logic [7:0]                frame_cnt_o
);

  typedef enum logic [2:0] {IDLE, ARM, WAIT_EN, WAIT_SOF, CAPTURE, SKIP} state_t;

  state_t     state;
  logic [1:0] buf_free;
  logic       next_buf;
  logic       vsync_q;
  logic       rx_en_q;
  logic [7:0] nframes_q;

  logic       vsync_rise;
  logic       rx_fall;
  logic [7:0] cnt_inc;

  assign vsync_rise = vsync_i & ~vsync_q;
  assign rx_fall    = rx_en_q & ~ch_rx_en_i;
  assign cnt_inc    = frame_cnt_o + 8'd1;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state              <= IDLE;
      buf_free           <= 2'b11;
      next_buf           <= 1'b0;
      vsync_q            <= 1'b0;
      rx_en_q            <= 1'b0;
      nframes_q          <= '0;
      cfg_rx_startaddr_o <= '0;
      cfg_rx_size_o      <= '0;
      cfg_rx_en_o        <= 1'b0;
      cfg_rx_clr_o       <= 1'b0;
      cam_en_o           <= 1'b0;
      frame_done_o       <= 1'b0;
      frame_idx_o        <= 1'b0;
      short_frame_o      <= 1'b0;
      overrun_o          <= 1'b0;
      busy_o             <= 1'b0;
      frame_cnt_o        <= '0;
    end else begin
      vsync_q       <= vsync_i;
      rx_en_q       <= ch_rx_en_i;
      cfg_rx_en_o   <= 1'b0;
      cfg_rx_clr_o  <= 1'b0;
      frame_done_o  <= 1'b0;
      short_frame_o <= 1'b0;
      overrun_o     <= 1'b0;

      if (buf_release_i && state != IDLE) buf_free[buf_release_idx_i] <= 1'b1;

      if (stop_i) begin
        // Only a programmed channel needs to be cleared on abort
        cam_en_o <= 1'b0;
        busy_o   <= 1'b0;
        state    <= IDLE;
        if (state == WAIT_EN || state == WAIT_SOF || state == CAPTURE) cfg_rx_clr_o <= 1'b1;
      end else begin
        case (state)
          IDLE: if (start_i) begin
            buf_free    <= 2'b11;
            next_buf    <= 1'b0;
            frame_cnt_o <= '0;
            busy_o      <= 1'b1;
            state       <= ARM;
          end
          ARM: if (!ch_rx_en_i) begin
            if (buf_free[next_buf]) begin
              cfg_rx_startaddr_o <= next_buf ? cfg_buf1_addr_i : cfg_buf0_addr_i;
              cfg_rx_size_o      <= cfg_frame_size_i;
              nframes_q          <= cfg_nframes_i;
              cfg_rx_en_o        <= 1'b1;
              state              <= WAIT_EN;
            end else begin
              state <= SKIP;
            end
          end
          WAIT_EN: if (ch_rx_en_i) state <= WAIT_SOF;
          WAIT_SOF: if (vsync_rise) begin
            cam_en_o <= 1'b1;
            state    <= CAPTURE;
          end
          CAPTURE: begin
            // Completion wins over a coincident vsync edge
            if (rx_fall) begin
              cam_en_o           <= 1'b0;
              frame_done_o       <= 1'b1;
              frame_idx_o        <= next_buf;
              buf_free[next_buf] <= 1'b0;
              next_buf           <= ~next_buf;
              frame_cnt_o        <= cnt_inc;
              if (nframes_q != 8'd0 && cnt_inc == nframes_q) begin
                busy_o <= 1'b0;
                state  <= IDLE;
              end else begin
                state <= ARM;
              end
            end else if (vsync_rise && ch_rx_en_i) begin
              cam_en_o      <= 1'b0;
              cfg_rx_clr_o  <= 1'b1;
              short_frame_o <= 1'b1;
              state         <= ARM;
            end
          end
          SKIP: if (vsync_rise) begin
            overrun_o <= 1'b1;
            state     <= ARM;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_udma_cpi_frame_sched.sv
// Directed bench for udma_cpi_frame_sched with a byte-counting RX channel model and scoreboard queues.
module tb_udma_cpi_frame_sched;
  localparam int AW = 19;
  localparam int TW = 20;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0, stop = 1'b0;
  logic [AW-1:0] buf0 = 19'h1000, buf1 = 19'h2000;
  logic [TW-1:0] fsize = 20'd64;
  logic [7:0]    nframes = 8'd2;
  logic          rel = 1'b0, rel_idx = 1'b0;
  logic          vsync = 1'b0;
  logic          ch_en = 1'b0;

  logic [AW-1:0] rx_addr;
  logic [TW-1:0] rx_size;
  logic          rx_en, rx_clr, cam_en, done, idx, short_f, ovr, busy;
  logic [7:0]    fcnt;

  int checks = 0, errors = 0;
  int en_cnt = 0, ov_cnt = 0, done_cnt = 0;
  int bytes = 0, size_q = 0;
  int o0, e0, d0;
  logic [AW-1:0] exp_addr[$];
  logic          exp_idx[$];

  always #5 clk = ~clk;

  udma_cpi_frame_sched #(.L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TW)) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .stop_i(stop),
    .cfg_buf0_addr_i(buf0), .cfg_buf1_addr_i(buf1), .cfg_frame_size_i(fsize),
    .cfg_nframes_i(nframes), .buf_release_i(rel), .buf_release_idx_i(rel_idx),
    .vsync_i(vsync), .ch_rx_en_i(ch_en),
    .cfg_rx_startaddr_o(rx_addr), .cfg_rx_size_o(rx_size), .cfg_rx_en_o(rx_en),
    .cfg_rx_clr_o(rx_clr), .cam_en_o(cam_en), .frame_done_o(done), .frame_idx_o(idx),
    .short_frame_o(short_f), .overrun_o(ovr), .busy_o(busy), .frame_cnt_o(fcnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed=timeout expected=event", tag);
  endtask

  // One clock: channel model reacts to the DUT, then the scoreboard consumes any outputs
  task automatic tick();
    @(posedge clk);
    #1;
    if (rx_clr) begin
      ch_en = 1'b0;
      bytes = 0;
    end else if (rx_en) begin
      ch_en  = 1'b1;
      bytes  = 0;
      size_q = int'(rx_size);
    end else if (ch_en && cam_en) begin
      bytes += 4;
      if (bytes >= size_q) ch_en = 1'b0;
    end
    if (rx_en) begin
      en_cnt++;
      chk("rx_en_expected", 32'(exp_addr.size() != 0), 1);
      if (exp_addr.size() != 0) chk("rx_startaddr", rx_addr, exp_addr.pop_front());
      chk("rx_size", rx_size, 64);
    end
    if (done) begin
      done_cnt++;
      chk("done_expected", 32'(exp_idx.size() != 0), 1);
      if (exp_idx.size() != 0) chk("frame_idx", idx, exp_idx.pop_front());
    end
    if (ovr) ov_cnt++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_en(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (rx_en) begin seen = 1'b1; break; end
    end
    if (!seen) timeout("wait_rx_en");
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) timeout("wait_frame_done");
  endtask

  task automatic sof();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // Arm, open the frame, and run it to completion
  task automatic full_frame();
    wait_en(10);
    tick();
    sof();
    wait_done(40);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_cam_en", cam_en, 0);
    chk("rst_frame_cnt", fcnt, 0);
    chk("rst_startaddr", rx_addr, 0);
    rstn = 1'b1;
    tick();

    // Two-frame capture
    exp_addr.push_back(19'h1000); exp_addr.push_back(19'h2000);
    exp_idx.push_back(1'b0);      exp_idx.push_back(1'b1);
    e0 = en_cnt;
    pulse_start();
    chk("t1_busy", busy, 1);
    chk("t1_en_not_yet", rx_en, 0);
    tick();
    chk("t1_en_timing", rx_en, 1);
    tick();
    sof();
    chk("t1_cam_en", cam_en, 1);
    wait_done(40);
    chk("t1_cnt1", fcnt, 1);
    chk("t1_cam_off", cam_en, 0);
    full_frame();
    chk("t1_cnt2", fcnt, 2);
    chk("t1_idle", busy, 0);
    chk("t1_en_pulses", en_cnt - e0, 2);
    tick();
    chk("t1_done_one_cycle", done, 0);

    // Overrun in continuous mode
    nframes = 8'd0;
    exp_addr.push_back(19'h1000); exp_addr.push_back(19'h2000);
    exp_idx.push_back(1'b0);      exp_idx.push_back(1'b1);
    pulse_start();
    full_frame();
    full_frame();
    o0 = ov_cnt;
    run(3);
    sof();
    chk("t2_overrun", ovr, 1);
    tick();
    chk("t2_overrun_one_cycle", ovr, 0);
    run(2);
    sof();
    run(2);
    chk("t2_overrun_per_vsync", ov_cnt - o0, 2);
    rel = 1'b1; rel_idx = 1'b0;
    exp_addr.push_back(19'h1000);
    tick();
    rel = 1'b0;
    run(2);
    sof();
    wait_en(5);
    chk("t2_rearm_addr", rx_addr, 19'h1000);
    chk("t2_overrun_total", ov_cnt - o0, 3);
    pulse_stop();
    chk("t2_stop_clr", rx_clr, 1);
    chk("t2_stop_busy", busy, 0);

    // Short frame, then stop in CAPTURE
    exp_addr.push_back(19'h1000); exp_addr.push_back(19'h1000);
    pulse_start();
    wait_en(10);
    tick();
    sof();
    for (int i = 0; i < 20 && bytes < 32; i++) tick();
    sof();
    chk("t3_short", short_f, 1);
    chk("t3_clr", rx_clr, 1);
    chk("t3_cam_off", cam_en, 0);
    chk("t3_cnt", fcnt, 0);
    wait_en(5);
    chk("t3_short_one_cycle", short_f, 0);
    tick();
    sof();
    run(3);
    pulse_stop();
    chk("t3_stop_clr", rx_clr, 1);
    chk("t3_stop_cam", cam_en, 0);
    chk("t3_stop_busy", busy, 0);

    // Stop coinciding with the channel finishing
    exp_addr.push_back(19'h1000);
    pulse_start();
    wait_en(10);
    tick();
    sof();
    d0 = done_cnt;
    for (int i = 0; i < 30 && ch_en; i++) tick();
    pulse_stop();
    chk("t4_no_done", done, 0);
    chk("t4_busy", busy, 0);
    run(2);
    chk("t4_done_cnt", done_cnt - d0, 0);

    // Async reset during CAPTURE of buffer 1
    exp_addr.push_back(19'h1000); exp_addr.push_back(19'h2000);
    exp_idx.push_back(1'b0);
    pulse_start();
    full_frame();
    wait_en(10);
    tick();
    sof();
    run(3);
    #2 rstn = 1'b0;
    #1;
    chk("t5_rst_cam", cam_en, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_addr", rx_addr, 0);
    chk("t5_rst_cnt", fcnt, 0);
    chk("t5_rst_clr", rx_clr, 0);
    ch_en = 1'b0;
    bytes = 0;
    #1 rstn = 1'b1;
    exp_addr.push_back(19'h1000);
    pulse_start();
    tick();
    chk("t5_restart_en", rx_en, 1);
    chk("t5_restart_addr", rx_addr, 19'h1000);

    // Completion and vsync edge in the same cycle
    tick();
    sof();
    for (int i = 0; i < 30 && ch_en; i++) tick();
    vsync = 1'b1;
    exp_idx.push_back(1'b0);
    tick();
    vsync = 1'b0;
    chk("t6_done", done, 1);
    chk("t6_no_short", short_f, 0);
    chk("t6_no_clr", rx_clr, 0);
    chk("t6_cnt", fcnt, 1);
    pulse_stop();
    chk("t6_stop_busy", busy, 0);
    run(2);

    chk("sb_addr_drained", exp_addr.size(), 0);
    chk("sb_idx_drained", exp_idx.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/udma_cpi_frame_sched.md
# udma_cpi_frame_sched

Ping-pong frame-capture scheduler for the CPI receive path. It programs the camera uDMA RX channel with alternating buffer addresses, one full frame per transfer. It gates camera capture on frame boundaries (vsync) and tracks buffer ownership between hardware and software, reporting completed, short and dropped frames. It sits between the register file and the camera interface/RX channel config ports, in the peripheral clock domain.

## Interface
- L2_AWIDTH_NOAL, 19, buffer address width
- TRANS_SIZE, 20, transfer size width
- clk_i  in  1  peripheral clock
- rstn_i  in  1  asynchronous reset, active low
- start_i  in  1  pulse: begin capture sequence (ignored unless IDLE)
- stop_i  in  1  pulse: abort, return to IDLE
- cfg_buf0_addr_i  in  L2_AWIDTH_NOAL  buffer 0 start address
- cfg_buf1_addr_i  in  L2_AWIDTH_NOAL  buffer 1 start address
- cfg_frame_size_i  in  TRANS_SIZE  bytes per frame
- cfg_nframes_i  in  8  frames to capture; 0 = continuous
- buf_release_i  in  1  pulse: software returns buffer buf_release_idx_i
- buf_release_idx_i  in  1  buffer index released
- vsync_i  in  1  camera vsync, already synchronised to clk_i
- ch_rx_en_i  in  1  RX channel busy
- cfg_rx_startaddr_o  out  L2_AWIDTH_NOAL  channel start address
- cfg_rx_size_o  out  TRANS_SIZE  channel transfer size
- cfg_rx_en_o  out  1  one-cycle channel enable pulse
- cfg_rx_clr_o  out  1  one-cycle channel clear pulse
- cam_en_o  out  1  camera capture enable
- frame_done_o  out  1  pulse: frame complete in buffer frame_idx_o
- frame_idx_o  out  1  index of last completed buffer
- short_frame_o  out  1  pulse: vsync arrived before frame_size bytes
- overrun_o  out  1  pulse: frame dropped, no free buffer
- busy_o  out  1  state != IDLE
- frame_cnt_o  out  8  frames completed since start

## Operation
- All outputs registered; every output resets to 0. Internal: buf_free[1:0] reset 2'b11, next_buf reset 0, vsync_q reset 0.
- vsync_rise = vsync_i & ~vsync_q; marks a frame boundary.
- States: IDLE, ARM, WAIT_EN, WAIT_SOF, CAPTURE, SKIP.
- IDLE: on start_i -> buf_free=11, next_buf=0, frame_cnt=0, go ARM.
- ARM:
  - Wait while ch_rx_en_i=1.
  - Then, if buf_free[next_buf]: load startaddr (buf0/buf1 by next_buf) and cfg_frame_size_i, pulse cfg_rx_en_o, go WAIT_EN.
  - Else go SKIP.
- WAIT_EN: ch_rx_en_i=1 -> WAIT_SOF.
- WAIT_SOF: vsync_rise -> cam_en_o=1, go CAPTURE.
- CAPTURE:
  - Completion: ch_rx_en_i falls (prev 1, now 0). Then cam_en_o=0, pulse frame_done_o, frame_idx_o=next_buf, buf_free[next_buf]=0, toggle next_buf, frame_cnt++.
  - After completion: if cfg_nframes_i!=0 and new frame_cnt==cfg_nframes_i, go IDLE; else go ARM.
  - Short frame: vsync_rise while ch_rx_en_i=1. Then cam_en_o=0, pulse cfg_rx_clr_o and short_frame_o. Buffer stays free and next_buf is unchanged. Go ARM.
  - Completion and vsync_rise in the same cycle counts as completion.
- SKIP: vsync_rise -> pulse overrun_o, go ARM. One overrun is reported per dropped frame.
- buf_release_i sets buf_free[idx] in any state except IDLE. Releasing an already-free buffer has no effect. The new value is visible to ARM the next cycle.
- stop_i has priority over all transitions in the same cycle:
  - cam_en_o=0; go IDLE.
  - Pulse cfg_rx_clr_o if the state was WAIT_EN, WAIT_SOF or CAPTURE.
- frame_cnt wraps at 255. In continuous mode the wrap is harmless.
- cfg_* inputs are sampled only in ARM.

## Timing
- start_i sampled at edge N -> ARM from N+1 -> cfg_rx_en_o high during cycle N+2, provided ch_rx_en_i=0 and the buffer is free.
- cfg_rx_startaddr_o and cfg_rx_size_o are valid in the cfg_rx_en_o cycle and held until the next ARM load.
- vsync_rise at edge M in WAIT_SOF -> cam_en_o high from M+1.
- ch_rx_en_i fall seen at edge K -> frame_done_o, frame_idx_o and frame_cnt_o updated at K+1, with cam_en_o low at K+1.
- All pulses (cfg_rx_en_o, cfg_rx_clr_o, frame_done_o, short_frame_o, overrun_o) last exactly one cycle.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No clr pulse is issued.

## Test plan
- Two-frame capture: nframes=2, buf0=0x1000, buf1=0x2000, size=64, channel model drops en after 64 bytes. Required: startaddr 0x1000 then 0x2000; frame_done with idx 0 then 1; frame_cnt=2; IDLE; cfg_rx_en_o pulsed twice.
- Overrun: continuous mode, no buf_release after two frames. Required: SKIP entered; one overrun_o per vsync_rise. After release of idx 0, the next ARM loads 0x1000.
- Short frame: vsync_rise after 32 of 64 bytes. Required: cfg_rx_clr_o and short_frame_o pulse; frame_cnt unchanged; re-arm with the same address.
- Stop in CAPTURE: stop_i. Required: cfg_rx_clr_o pulse, cam_en_o=0, busy_o=0 next cycle. Simultaneous stop_i and ch_rx_en_i fall gives no frame_done_o.
- Async reset during CAPTURE. Required: all outputs 0 immediately. A subsequent start_i begins with buffer 0.
- Coincidence case: completion and vsync_rise in the same cycle. Required: frame_done_o only, no short_frame_o.
